// File: rtl/workout_scheduler_top.sv
// Training session scheduler: latches a user profile, derives how many fixed-length
// workouts burn the calorie target, then counts each workout down and signals its end.

module workout_calc (
  input  logic [1:0] cal,
  input  logic [2:0] w,
  input  logic       gender,
  input  logic [1:0] met,
  output logic [7:0] n
);
  logic [7:0]  target;
  logic [6:0]  kg;
  logic [3:0]  met_v;
  logic [12:0] e_m;
  logic [16:0] e_f9;
  logic [12:0] e;
  logic [4:0]  burn;

  // Widths sized so no intermediate can overflow: E <= 6930, E*9 <= 62370,
  // target + burn - 1 <= 216.
  always_comb begin
    target = 8'd50 * ({6'd0, cal} + 8'd1);
    kg     = 7'd40 + 7'd10 * {4'd0, w};
    met_v  = 4'd3 + {1'b0, met, 1'b0};
    e_m    = {9'd0, met_v} * {6'd0, kg} * 13'd7;
    e_f9   = {4'd0, e_m} * 17'd9;
    e      = gender ? 13'(e_f9 / 17'd10) : e_m;
    burn   = 5'(e / 13'd400);
    n      = (target + {3'd0, burn} - 8'd1) / {3'd0, burn};
  end
endmodule

module workout_scheduler_top #(
  parameter int TICK_DIV     = 1,
  parameter int WORKOUT_TIME = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       skip,
  input  logic [1:0] Cal,
  input  logic [2:0] W,
  input  logic       gender,
  input  logic [1:0] MET,
  output logic [7:0] workout_num,
  output logic [5:0] time_remain,
  output logic       buzzer
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WORK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cal_q, cal_d;
  logic [2:0]    w_q, w_d;
  logic          gender_q, gender_d;
  logic [1:0]    met_q, met_d;
  logic [7:0]    wn_q, wn_d;
  logic [5:0]    tr_q, tr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          buzzer_q, buzzer_d;
  logic          tick, end_ev;
  logic [7:0]    n_calc;

  workout_calc u_calc (
    .cal    (cal_q),
    .w      (w_q),
    .gender (gender_q),
    .met    (met_q),
    .n      (n_calc)
  );

  always_comb begin
    state_d  = state_q;
    cal_d    = cal_q;
    w_d      = w_q;
    gender_d = gender_q;
    met_d    = met_q;
    wn_d     = wn_q;
    tr_d     = tr_q;
    presc_d  = presc_q;
    buzzer_d = 1'b0;
    tick     = 1'b0;
    end_ev   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cal_d = Cal; w_d = W; gender_d = gender; met_d = MET;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        wn_d    = n_calc;
        tr_d    = 6'(WORKOUT_TIME);
        presc_d = '0;
        state_d = S_WORK;
      end
      S_WORK: begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        // skip and a natural expiry in the same cycle still end only one workout
        end_ev  = skip || (tick && tr_q == 6'd1);
        if (end_ev) begin
          buzzer_d = 1'b1;
          presc_d  = '0;
          if (wn_q > 8'd1) begin
            wn_d = wn_q - 8'd1;
            tr_d = 6'(WORKOUT_TIME);
          end else begin
            wn_d    = 8'd0;
            tr_d    = 6'd0;
            state_d = S_DONE;
          end
        end else if (tick && tr_q > 6'd1) begin
          tr_d = tr_q - 6'd1;
        end
      end
      S_DONE: begin
        buzzer_d = 1'b1;
        if (start) begin
          cal_d = Cal; w_d = W; gender_d = gender; met_d = MET;
          buzzer_d = 1'b0;
          state_d  = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cal_q    <= '0;
      w_q      <= '0;
      gender_q <= 1'b0;
      met_q    <= '0;
      wn_q     <= '0;
      tr_q     <= '0;
      presc_q  <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cal_q    <= cal_d;
      w_q      <= w_d;
      gender_q <= gender_d;
      met_q    <= met_d;
      wn_q     <= wn_d;
      tr_q     <= tr_d;
      presc_q  <= presc_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign workout_num = wn_q;
  assign time_remain = tr_q;
  assign buzzer      = buzzer_q;
endmodule

// File: tb/tb_workout_scheduler_top.sv
// Bench for workout_scheduler_top: two instances (TICK_DIV 1 and 4) on shared stimulus,
// checked against a cycles-elapsed reference model plus table and directed sequences.

module tb_workout_scheduler_top;
  localparam int WT = 60;
  localparam int M_IDLE = 0, M_CALC = 1, M_WORK = 2, M_DONE = 3;

  logic       clk, reset, start, skip, gender;
  logic [1:0] cal, met;
  logic [2:0] w;
  logic [7:0] wn1, wn4;
  logic [5:0] tr1, tr4;
  logic       bz1, bz4;

  int n_chk = 0, n_pass = 0;

  workout_scheduler_top #(.TICK_DIV(1), .WORKOUT_TIME(WT)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .skip(skip), .Cal(cal), .W(w),
    .gender(gender), .MET(met), .workout_num(wn1), .time_remain(tr1), .buzzer(bz1));

  workout_scheduler_top #(.TICK_DIV(4), .WORKOUT_TIME(WT)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .skip(skip), .Cal(cal), .W(w),
    .gender(gender), .MET(met), .workout_num(wn4), .time_remain(tr4), .buzzer(bz4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, workouts left and cycles elapsed in the current workout
  int ms[2], ml[2], mc[2], mb[2];
  int lc[2], lw[2], lg[2], lm[2];
  int td[2] = '{1, 4};

  function automatic int calc_n(int c, int wv, int g, int m);
    int e, burn, tgt;
    tgt = 50 * (c + 1);
    e = (3 + 2 * m) * (40 + 10 * wv) * 7;
    if (g != 0) e = e * 9 / 10;
    burn = e / 400;
    return (tgt + burn - 1) / burn;
  endfunction

  function automatic int exp_wn(int k);
    return (ms[k] == M_WORK) ? ml[k] : 0;
  endfunction

  function automatic int exp_tr(int k);
    return (ms[k] == M_WORK) ? WT - mc[k] / td[k] : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = M_IDLE; ml[k] = 0; mc[k] = 0; mb[k] = 0;
      lc[k] = 0; lw[k] = 0; lg[k] = 0; lm[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        ms[k] = M_IDLE; ml[k] = 0; mc[k] = 0; mb[k] = 0;
        lc[k] = 0; lw[k] = 0; lg[k] = 0; lm[k] = 0;
      end else begin
        case (ms[k])
          M_IDLE: begin
            mb[k] = 0;
            if (start) begin
              lc[k] = cal; lw[k] = w; lg[k] = gender; lm[k] = met; ms[k] = M_CALC;
            end
          end
          M_CALC: begin
            mb[k] = 0; ml[k] = calc_n(lc[k], lw[k], lg[k], lm[k]); mc[k] = 0; ms[k] = M_WORK;
          end
          M_WORK: begin
            mb[k] = 0;
            if (skip || mc[k] + 1 == WT * td[k]) begin
              mb[k] = 1;
              if (ml[k] > 1) begin ml[k]--; mc[k] = 0; end
              else begin ml[k] = 0; ms[k] = M_DONE; end
            end else mc[k]++;
          end
          default: begin
            mb[k] = 1;
            if (start) begin
              lc[k] = cal; lw[k] = w; lg[k] = gender; lm[k] = met;
              ms[k] = M_CALC; mb[k] = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_model(string tag);
    chk({tag, " wn1"}, int'(wn1), exp_wn(0));
    chk({tag, " tr1"}, int'(tr1), exp_tr(0));
    chk({tag, " bz1"}, int'(bz1), mb[0]);
    chk({tag, " wn4"}, int'(wn4), exp_wn(1));
    chk({tag, " tr4"}, int'(tr4), exp_tr(1));
    chk({tag, " bz4"}, int'(bz4), mb[1]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; skip = 0; reset = 0;
    step();
    reset = 1;
    step();
  endtask

  task automatic start_session(int c, int wv, int g, int m);
    cal = 2'(c); w = 3'(wv); gender = g[0]; met = 2'(m);
    start = 1; step();
    start = 0; step();
  endtask

  typedef struct { int c; int wv; int g; int m; int n; } vec_t;
  vec_t vecs[7];
  int pulses;

  initial begin
    vecs[0] = '{1, 3, 0, 1, 17};
    vecs[1] = '{1, 3, 1, 1, 20};
    vecs[2] = '{3, 0, 1, 0, 200};
    vecs[3] = '{0, 7, 0, 3, 3};
    vecs[4] = '{2, 2, 0, 2, 22};
    vecs[5] = '{3, 7, 1, 3, 14};
    vecs[6] = '{0, 0, 0, 0, 25};

    reset = 0; start = 0; skip = 0; cal = 0; w = 0; gender = 0; met = 0;
    model_reset();
    #12;
    chk_model("reset");
    @(posedge clk); #1;
    reset = 1;

    // Profile table: N appears 2 clocks after start is sampled
    for (int i = 0; i < 7; i++) begin
      do_reset();
      start_session(vecs[i].c, vecs[i].wv, vecs[i].g, vecs[i].m);
      chk("tbl wn", int'(wn1), vecs[i].n);
      chk("tbl tr", int'(tr1), WT);
      chk("tbl bz", int'(bz1), 0);
      chk_model("tbl");
    end

    // Full N=3 session at TICK_DIV=1
    do_reset();
    start_session(0, 7, 0, 3);
    pulses = 0;
    for (int i = 1; i <= 180; i++) begin
      step();
      chk_model("run3");
      if (i < 180 && bz1) pulses++;
      if (i == 59) chk("run3 tr at 59", int'(tr1), 1);
      if (i == 60) chk("run3 wn after first end", int'(wn1), 2);
      if (i == 3) chk("div4 tr hold", int'(tr4), 60);
      if (i == 4) chk("div4 tr first dec", int'(tr4), 59);
      if (i == 8) chk("div4 tr second dec", int'(tr4), 58);
    end
    chk("run3 pulses", pulses, 2);
    chk("run3 done wn", int'(wn1), 0);
    chk("run3 done tr", int'(tr1), 0);
    chk("run3 done bz", int'(bz1), 1);
    repeat (3) step();
    chk("run3 bz held", int'(bz1), 1);
    chk("run3 tr frozen", int'(tr1), 0);

    // Skip mid-workout, then skip coinciding with natural end
    do_reset();
    start_session(1, 3, 0, 1);
    repeat (20) step();
    chk("skip pre tr", int'(tr1), 40);
    skip = 1; step(); skip = 0;
    chk("skip bz", int'(bz1), 1);
    chk("skip wn", int'(wn1), 16);
    chk("skip tr", int'(tr1), 60);
    step();
    chk("skip bz drop", int'(bz1), 0);
    repeat (58) step();
    chk("coinc pre tr", int'(tr1), 1);
    skip = 1; step(); skip = 0;
    chk("coinc wn", int'(wn1), 15);
    chk("coinc tr", int'(tr1), 60);
    chk("coinc bz", int'(bz1), 1);
    chk_model("coinc");

    // start held during WORK has no effect
    cal = 3; w = 0; gender = 1; met = 0;
    start = 1; repeat (5) step(); start = 0;
    chk("start in work wn", int'(wn1), 15);
    chk("start in work tr", int'(tr1), 55);
    chk_model("start in work");

    // Asynchronous reset between clock edges
    #2;
    reset = 0;
    #1;
    model_reset();
    chk_model("async reset");
    step();
    reset = 1;
    step();

    // Finish via skips, then restart from DONE with a new profile
    start_session(0, 7, 0, 3);
    skip = 1; repeat (3) step(); skip = 0;
    chk_model("skip to done");
    chk("done bz1", int'(bz1), 1);
    chk("done bz4", int'(bz4), 1);
    repeat (2) step();
    chk("done held bz4", int'(bz4), 1);
    cal = 1; w = 3; gender = 0; met = 1;
    start = 1; step(); start = 0;
    chk("calc bz1 drop", int'(bz1), 0);
    chk("calc bz4 drop", int'(bz4), 0);
    step();
    chk("restart wn1", int'(wn1), 17);
    chk("restart wn4", int'(wn4), 17);
    repeat (3) step();
    chk("restart div4 hold", int'(tr4), 60);
    step();
    chk("restart div4 dec", int'(tr4), 59);
    chk_model("restart");

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      start  = ($urandom % 16) == 0;
      skip   = ($urandom % 6) == 0;
      cal    = 2'($urandom);
      w      = 3'($urandom);
      gender = 1'($urandom);
      met    = 2'($urandom);
      reset  = ($urandom % 1500) != 0;
      step();
      chk_model("rand");
    end
    reset = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
